// File: rtl/key_onepulse_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Imported by the debouncer top.
package key_onepulse_debounce_pkg;

   typedef enum logic [1:0] {
      KEY_ST_UP      = 2'b00,
      KEY_ST_PEND_DN = 2'b01,
      KEY_ST_DOWN    = 2'b10,
      KEY_ST_PEND_UP = 2'b11
   } key_st_t;

   localparam int KEY_DB_CYCLES = 1_000_000;
   localparam int KEY_CNT_W     = 20;

   // Debounced level is high once a press is accepted, until release is.
   function automatic logic key_st_db(input key_st_t st);
      return (st == KEY_ST_DOWN) || (st == KEY_ST_PEND_UP);
   endfunction

endpackage

// File: rtl/key_onepulse_debounce_sync2.sv
// Generic two-flop synchroniser, async active-low reset to 0.
// Shared by any asynchronous pin input.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/key_onepulse_debounce.sv
// Push-button synchroniser + debouncer emitting one-cycle
// press/release strobes and a clean level.
module key_onepulse_debounce
   import key_onepulse_debounce_pkg::*;
#(
   parameter int DB_CYCLES = KEY_DB_CYCLES,
   parameter int CNT_W     = KEY_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_db,
   output logic key_pulse,
   output logic key_rel_pulse
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic             w_key_s;
   key_st_t          r_st;
   key_st_t          w_st_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             w_p_nx;
   logic             w_r_nx;
   logic             r_db;
   logic             r_p;
   logic             r_r;

   sync2 #(
      .W(1)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (key_in),
      .o_q  (w_key_s)
   );

   // Counter is held at 0 outside the pending states.
   always_comb begin
      w_st_nx  = r_st;
      w_cnt_nx = '0;
      w_p_nx   = 1'b0;
      w_r_nx   = 1'b0;
      unique case (r_st)
         KEY_ST_UP: begin
            if (w_key_s) w_st_nx = KEY_ST_PEND_DN;
         end
         KEY_ST_PEND_DN: begin
            if (!w_key_s) begin
               w_st_nx = KEY_ST_UP;
            end else if (r_cnt == DB_LAST) begin
               w_st_nx = KEY_ST_DOWN;
               w_p_nx  = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         KEY_ST_DOWN: begin
            if (!w_key_s) w_st_nx = KEY_ST_PEND_UP;
         end
         KEY_ST_PEND_UP: begin
            if (w_key_s) begin
               w_st_nx = KEY_ST_DOWN;
            end else if (r_cnt == DB_LAST) begin
               w_st_nx = KEY_ST_UP;
               w_r_nx  = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         default: begin
            w_st_nx = KEY_ST_UP;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st  <= KEY_ST_UP;
         r_cnt <= '0;
         r_db  <= 1'b0;
         r_p   <= 1'b0;
         r_r   <= 1'b0;
      end else begin
         r_st  <= w_st_nx;
         r_cnt <= w_cnt_nx;
         r_db  <= key_st_db(w_st_nx);
         r_p   <= w_p_nx;
         r_r   <= w_r_nx;
      end
   end

   assign key_db        = r_db;
   assign key_pulse     = r_p;
   assign key_rel_pulse = r_r;

endmodule

// File: tb/tb_key_onepulse_debounce.sv
// Self-checking bench for key_onepulse_debounce (DB_CYCLES=4):
// directed tables, corner sequences and a run-length reference model.
module tb_key_onepulse_debounce;

   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_in = 1'b0;
   logic key_db;
   logic key_pulse;
   logic key_rel_pulse;

   int errors = 0;
   int checks = 0;

   key_onepulse_debounce #(
      .DB_CYCLES(DB),
      .CNT_W    (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in),
      .key_db       (key_db),
      .key_pulse    (key_pulse),
      .key_rel_pulse(key_rel_pulse)
   );

   always #5 clk = ~clk;

   // Reference: level flips once the synchronised input has disagreed
   // with it for DB+1 consecutive edges; any agreement restarts the run.
   logic m_d1, m_d2, m_db, m_p, m_r;
   int   m_run;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_d1  <= 1'b0;
         m_d2  <= 1'b0;
         m_db  <= 1'b0;
         m_p   <= 1'b0;
         m_r   <= 1'b0;
         m_run <= 0;
      end else begin
         m_d1 <= key_in;
         m_d2 <= m_d1;
         m_p  <= 1'b0;
         m_r  <= 1'b0;
         if (m_d2 != m_db) begin
            if (m_run == DB) begin
               m_db  <= m_d2;
               m_p   <= m_d2;
               m_r   <= ~m_d2;
               m_run <= 0;
            end else begin
               m_run <= m_run + 1;
            end
         end else begin
            m_run <= 0;
         end
      end
   end

   // Level-select FSM driven by key_pulse: level_1,2,3,endless.
   logic [1:0] lvl;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lvl <= 2'd0;
      else if (key_pulse) lvl <= lvl + 2'd1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input logic k);
      key_in = k;
      @(posedge clk);
      @(negedge clk);
      chk("mdl_pulse", key_pulse, m_p);
      chk("mdl_rel", key_rel_pulse, m_r);
      chk("mdl_db", key_db, m_db);
   endtask

   typedef struct {
      logic k;
      logic p;
      logic r;
      logic db;
   } vec_t;

   vec_t t1[8];
   vec_t t5[7];
   logic bseq[18];

   initial begin
      int np, nr, idx;

      for (int i = 0; i < 8; i++)
         t1[i] = '{k: 1'b1, p: (i == 6), r: 1'b0, db: (i >= 6)};
      for (int i = 0; i < 7; i++)
         t5[i] = '{k: 1'b1, p: (i == 6), r: 1'b0, db: (i >= 6)};
      for (int i = 0; i < 18; i++)
         bseq[i] = (i >= 8) ? 1'b1 : ((i % 4) < 2);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_db", key_db, 0);
      chk("rst_pulse", key_pulse, 0);
      chk("rst_rel", key_rel_pulse, 0);
      rst_n = 1'b1;
      repeat (3) tick(1'b0);

      // 1: clean press, pulse after edge DB+2
      for (int i = 0; i < 8; i++) begin
         tick(t1[i].k);
         chk("t1_pulse", key_pulse, t1[i].p);
         chk("t1_rel", key_rel_pulse, t1[i].r);
         chk("t1_db", key_db, t1[i].db);
      end

      // 2: long hold gives no repeat, then release
      np = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1'b1);
         np += key_pulse;
      end
      chk("t2_hold_pulses", np, 0);
      chk("t2_hold_db", key_db, 1);
      nr = 0;
      idx = -1;
      for (int i = 0; i < 8; i++) begin
         tick(1'b0);
         if (key_rel_pulse) begin
            nr++;
            idx = i;
         end
      end
      chk("t2_rel_count", nr, 1);
      chk("t2_rel_edge", idx, 6);
      chk("t2_rel_db", key_db, 0);

      // 3: bouncing press, one pulse DB+2 edges after final rise
      np = 0;
      idx = -1;
      for (int i = 0; i < 18; i++) begin
         tick(bseq[i]);
         if (key_pulse) begin
            np++;
            idx = i;
         end
      end
      chk("t3_pulse_count", np, 1);
      chk("t3_pulse_edge", idx, 14);

      // 4: short release glitch while down is rejected
      np = 0;
      nr = 0;
      for (int i = 0; i < 14; i++) begin
         tick(i < 2 ? 1'b0 : 1'b1);
         np += key_pulse;
         nr += key_rel_pulse;
         chk("t4_db_held", key_db, 1);
      end
      chk("t4_pulses", np, 0);
      chk("t4_rels", nr, 0);
      repeat (9) tick(1'b0);
      chk("t4_released", key_db, 0);

      // 5: async reset mid-debounce, key held through release
      repeat (4) tick(1'b1);
      key_in = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_db", key_db, 0);
      chk("t5_rst_pulse", key_pulse, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick(t5[i].k);
         chk("t5_pulse", key_pulse, t5[i].p);
         chk("t5_db", key_db, t5[i].db);
      end
      repeat (2) tick(1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_db", key_db, 0);
      key_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick(1'b0);

      // 6: key_pulse advances the level FSM once per press
      chk("t6_lvl_start", lvl, 0);
      for (int i = 0; i < 4; i++) begin
         repeat (8) tick(1'b1);
         repeat (8) tick(1'b0);
         chk("t6_level", lvl, (i + 1) % 4);
      end

      // Random runs against the reference model
      for (int i = 0; i < 120; i++) begin
         logic lv;
         int   len;
         lv  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 9);
         repeat (len) tick(lv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
